// File: rtl/pipelined_cla_adder_if.sv
// Valid/ready bus for pipelined_cla_adder.
//   Input side : in_valid, in_ready, a, b, cin, sub
//   Output side: out_valid, out_ready, sum, cout, ovf
// The master modport belongs to whoever sources operands and sinks results.
// The slave modport belongs to the adder.
interface pipelined_cla_adder_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipelined_cla_adder.sv
// Pipelined add/subtract built from BLOCK-bit carry-lookahead slices, one slice per stage.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset; discards all in-flight operations
//   bus_io : slave side of pipelined_cla_adder_if. Its WIDTH must equal this module's WIDTH.
//            in_valid/in_ready/a/b/cin/sub form the operand handshake.
//            out_valid/out_ready/sum/cout/ovf form the result handshake.
// Result = a + (b ^ {WIDTH{sub}}) + (cin ^ sub). cout is bit WIDTH of that sum.
// ovf is the carry into the MSB XOR the carry out of the MSB.
// Latency is WIDTH/BLOCK cycles. Throughput is one operation per cycle while out_ready is high.
module pipelined_cla_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned BLOCK = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pipelined_cla_adder_if.slave bus_io
);

  if (BLOCK == 0 || (WIDTH % BLOCK) != 0) begin : gen_bad_params
    $error("pipelined_cla_adder: WIDTH must be a non-zero multiple of BLOCK");
  end

  localparam int unsigned Stages = (BLOCK == 0) ? 1 : WIDTH / BLOCK;

  typedef logic [WIDTH-1:0] word_t;

  // Stage k registers hold the operands and carry consumed by slice k.
  // They also hold the sum bits already produced by slices below k.
  word_t             a_q [Stages];
  word_t             b_q [Stages];
  word_t             s_q [Stages];
  logic [Stages-1:0] c_q;
  logic [Stages-1:0] v_q;

  word_t             s_next   [Stages];
  logic [Stages-1:0] slice_co;
  logic [Stages-1:0] slice_cm;

  logic              out_valid_q;
  word_t             sum_q;
  logic              cout_q;
  logic              ovf_q;

  logic              advance;
  logic              accept;

  // The whole pipe moves in lockstep, so bubbles are not squeezed out during a stall.
  assign advance         = !out_valid_q || bus_io.out_ready;
  assign accept          = bus_io.in_valid && advance;
  assign bus_io.in_ready = advance;

  assign bus_io.out_valid = out_valid_q;
  assign bus_io.sum       = sum_q;
  assign bus_io.cout      = cout_q;
  assign bus_io.ovf       = ovf_q;

  // One carry-lookahead slice per stage.
  always_comb begin
    logic [BLOCK-1:0] p;
    logic [BLOCK-1:0] g;
    logic [BLOCK:0]   c;
    slice_co = '0;
    slice_cm = '0;
    for (int k = 0; k < Stages; k++) begin
      s_next[k] = s_q[k];
      p         = a_q[k][k*BLOCK +: BLOCK] ^ b_q[k][k*BLOCK +: BLOCK];
      g         = a_q[k][k*BLOCK +: BLOCK] & b_q[k][k*BLOCK +: BLOCK];
      c         = '0;
      c[0]      = c_q[k];
      for (int i = 0; i < BLOCK; i++) begin
        c[i+1] = g[i] | (p[i] & c[i]);
      end
      s_next[k][k*BLOCK +: BLOCK] = p ^ c[BLOCK-1:0];
      slice_co[k]                 = c[BLOCK];
      slice_cm[k]                 = c[BLOCK-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < Stages; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
      c_q         <= '0;
      v_q         <= '0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (advance) begin
      v_q[0] <= accept;
      if (accept) begin
        // Subtraction becomes addition of ~b, with the borrow-in turned into a carry-in.
        a_q[0] <= bus_io.a;
        b_q[0] <= bus_io.b ^ {WIDTH{bus_io.sub}};
        c_q[0] <= bus_io.cin ^ bus_io.sub;
      end
      for (int k = 1; k < Stages; k++) begin
        v_q[k] <= v_q[k-1];
        a_q[k] <= a_q[k-1];
        b_q[k] <= b_q[k-1];
        s_q[k] <= s_next[k-1];
        c_q[k] <= slice_co[k-1];
      end
      out_valid_q <= v_q[Stages-1];
      sum_q       <= s_next[Stages-1];
      cout_q      <= slice_co[Stages-1];
      ovf_q       <= slice_cm[Stages-1] ^ slice_co[Stages-1];
    end
  end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench for pipelined_cla_adder (WIDTH=16, BLOCK=4).
module tb_pipelined_cla_adder;

  localparam int unsigned W = 16;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  // Directed vectors and their hand-computed results.
  localparam logic [15:0] DA [5] = '{16'hFFFF, 16'h7FFF, 16'h8000, 16'h0005, 16'h0007};
  localparam logic [15:0] DB [5] = '{16'h0001, 16'h0001, 16'h8000, 16'h0007, 16'h0005};
  localparam logic        DC [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam logic        DS [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  localparam logic [15:0] ES [5] = '{16'h0000, 16'h8000, 16'h0000, 16'hFFFE, 16'h0001};
  localparam logic        EC [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  localparam logic        EO [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  pipelined_cla_adder_if #(.WIDTH(W)) bus ();

  pipelined_cla_adder #(
    .WIDTH(W),
    .BLOCK(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus_io(bus)
  );

  always #5 clk = ~clk;

  exp_t        sb[$];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic        accepted;

  function automatic exp_t golden(input logic [15:0] a, input logic [15:0] b,
                                  input logic cin, input logic sub);
    logic [15:0] bb;
    logic [16:0] r;
    exp_t        e;
    bb     = b ^ {16{sub}};
    r      = {1'b0, a} + {1'b0, bb} + {16'b0, cin ^ sub};
    e.sum  = r[15:0];
    e.cout = r[16];
    e.ovf  = (a[15] == bb[15]) && (r[15] != a[15]);
    return e;
  endfunction

  // One clock: drive just after the edge, then settle so outputs can be read mid-cycle.
  task automatic step(input logic iv, input logic [15:0] a, input logic [15:0] b,
                      input logic cin, input logic sub, input logic ordy);
    @(posedge clk);
    #1;
    bus.in_valid  = iv;
    bus.a         = a;
    bus.b         = b;
    bus.cin       = cin;
    bus.sub       = sub;
    bus.out_ready = ordy;
    #1;
    accepted = iv && bus.in_ready;
    if (accepted) sb.push_back(golden(a, b, cin, sub));
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++;
      $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.sum !== 16'h0000) begin n_err++;
      $display("FAIL reset_sum: got %h want 0000", bus.sum); end
    n_cmp++; if (bus.cout !== 1'b0) begin n_err++;
      $display("FAIL reset_cout: got %b want 0", bus.cout); end
    n_cmp++; if (bus.ovf !== 1'b0) begin n_err++;
      $display("FAIL reset_ovf: got %b want 0", bus.ovf); end
    rst_n = 1'b1;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++;
      $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_directed();
    int lat;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, DA[i], DB[i], DC[i], DS[i], 1'b1);
      n_cmp++; if (accepted !== 1'b1) begin n_err++;
        $display("FAIL dir%0d_accept: got %b want 1", i, accepted); end
      lat = 0;
      do begin
        step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
        lat++;
      end while (bus.out_valid !== 1'b1 && lat < 20);
      // The first idle step lands on the accept edge, so subtract it.
      n_cmp++; if (lat - 1 != 4) begin n_err++;
        $display("FAIL dir%0d_latency: got %0d want 4", i, lat - 1); end
      n_cmp++; if (bus.sum !== ES[i]) begin n_err++;
        $display("FAIL dir%0d_sum: got %h want %h", i, bus.sum, ES[i]); end
      n_cmp++; if (bus.cout !== EC[i]) begin n_err++;
        $display("FAIL dir%0d_cout: got %b want %b", i, bus.cout, EC[i]); end
      n_cmp++; if (bus.ovf !== EO[i]) begin n_err++;
        $display("FAIL dir%0d_ovf: got %b want %b", i, bus.ovf, EO[i]); end
      if (sb.size() > 0) void'(sb.pop_front());
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] oa [8];
    logic [15:0] ob [8];
    logic        oc [8];
    logic        os [8];
    int          i = 0;
    int          got = 0;
    logic        ordy;
    logic        held_valid = 1'b0;
    exp_t        held;
    exp_t        e;
    for (int k = 0; k < 8; k++) begin
      oa[k] = 16'($urandom()); ob[k] = 16'($urandom());
      oc[k] = 1'($urandom()); os[k] = 1'($urandom());
    end
    for (int t = 0; t < 30; t++) begin
      ordy = !(t >= 6 && t <= 8);
      if (i < 8) step(1'b1, oa[i], ob[i], oc[i], os[i], ordy);
      else       step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, ordy);
      if (accepted) i++;
      if (bus.out_valid && !ordy) begin
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++;
          $display("FAIL b2b_stall_in_ready t=%0d: got %b want 0", t, bus.in_ready); end
        if (held_valid) begin
          n_cmp++; if ({bus.sum, bus.cout, bus.ovf} !== held) begin n_err++;
            $display("FAIL b2b_hold t=%0d: got %h/%b/%b want %h/%b/%b", t, bus.sum,
                     bus.cout, bus.ovf, held.sum, held.cout, held.ovf); end
        end else begin
          held       = {bus.sum, bus.cout, bus.ovf};
          held_valid = 1'b1;
        end
      end else if (bus.out_valid && ordy) begin
        got++;
        n_cmp++;
        if (sb.size() == 0) begin n_err++;
          $display("FAIL b2b_extra_result t=%0d: got sum %h want none", t, bus.sum);
        end else begin
          e = sb.pop_front();
          if ({bus.sum, bus.cout, bus.ovf} !== e) begin n_err++;
            $display("FAIL b2b_result t=%0d: got %h/%b/%b want %h/%b/%b", t, bus.sum,
                     bus.cout, bus.ovf, e.sum, e.cout, e.ovf); end
        end
      end
    end
    n_cmp++; if (got != 8 || sb.size() != 0) begin n_err++;
      $display("FAIL b2b_count: got %0d results (%0d pending) want 8 (0)", got, sb.size()); end
  endtask

  task automatic test_reset_flush();
    int   lat;
    exp_t e;
    for (int k = 0; k < 4; k++) step(1'b1, 16'h0101 * 16'(k + 1), 16'h0010, 1'b0, 1'b0, 1'b1);
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.sum !== 16'h0111) begin n_err++;
      $display("FAIL flush_pre: got valid %b sum %h want 1 0111", bus.out_valid, bus.sum); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++;
      $display("FAIL flush_out_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.sum !== 16'h0000) begin n_err++;
      $display("FAIL flush_sum: got %h want 0000", bus.sum); end
    sb.delete();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++;
        $display("FAIL flush_stale cycle %0d: got valid %b want 0", k, bus.out_valid); end
    end
    step(1'b1, 16'h1234, 16'h0FF0, 1'b1, 1'b0, 1'b1);
    lat = 0;
    do begin
      step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
      lat++;
    end while (bus.out_valid !== 1'b1 && lat < 20);
    n_cmp++; if (lat - 1 != 4) begin n_err++;
      $display("FAIL flush_latency: got %0d want 4", lat - 1); end
    n_cmp++; if (bus.sum !== 16'h2225 || bus.cout !== 1'b0) begin n_err++;
      $display("FAIL flush_result: got %h/%b want 2225/0", bus.sum, bus.cout); end
    if (sb.size() > 0) void'(sb.pop_front());
  endtask

  task automatic test_random();
    int unsigned issued = 0;
    int unsigned cyc = 0;
    logic [15:0] pa, pb;
    logic        pc, ps, iv, ordy;
    exp_t        e;
    pa = 16'($urandom()); pb = 16'($urandom()); pc = 1'($urandom()); ps = 1'($urandom());
    while ((issued < 10000 || sb.size() != 0) && cyc < 60000) begin
      iv   = (issued < 10000) && ($urandom_range(3) != 0);
      ordy = ($urandom_range(3) != 0);
      step(iv, pa, pb, pc, ps, ordy);
      cyc++;
      if (accepted) begin
        issued++;
        pa = 16'($urandom()); pb = 16'($urandom()); pc = 1'($urandom()); ps = 1'($urandom());
      end
      if (bus.out_valid && ordy) begin
        n_cmp++;
        if (sb.size() == 0) begin n_err++;
          $display("FAIL rand_extra_result cyc=%0d: got sum %h want none", cyc, bus.sum);
        end else begin
          e = sb.pop_front();
          if ({bus.sum, bus.cout, bus.ovf} !== e) begin n_err++;
            $display("FAIL rand_result cyc=%0d: got %h/%b/%b want %h/%b/%b", cyc, bus.sum,
                     bus.cout, bus.ovf, e.sum, e.cout, e.ovf); end
        end
      end
    end
    n_cmp++; if (issued != 10000 || sb.size() != 0) begin n_err++;
      $display("FAIL rand_drain: got %0d issued %0d pending want 10000 0", issued, sb.size()); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got time limit reached want normal completion");
    $fatal(1, "watchdog expired");
  end

endmodule
